// File: rtl/titan_id_queue.sv
// Elastic decode-to-execute queue: DEPTH-entry valid/ready FIFO of decoded bundles with flush.
// Optional same-cycle bypass of an empty queue when TITAN_IDQ_BYPASS_EN is defined.
module titan_id_queue #(
  parameter int unsigned DATA_WIDTH  = 160,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  input  logic [DATA_WIDTH-1:0] id_data_i,
  output logic                  id_ready_o,
  output logic                  ex_valid_o,
  output logic [DATA_WIDTH-1:0] ex_data_o,
  input  logic                  ex_ready_i,
  output logic [CW-1:0]         count_o,
  output logic                  almost_full_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty, bypass, push, pop;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    id_ready_o = ~rst_i & ~full;
`ifdef TITAN_IDQ_BYPASS_EN
    // Empty queue with a consumer waiting: hand the bundle straight through, never stored.
    bypass     = empty & id_valid_i & ex_ready_i & ~flush_i & ~rst_i;
    ex_valid_o = ~empty | (id_valid_i & ~rst_i & ~flush_i);
    ex_data_o  = empty ? id_data_i : mem_q[rp_q];
`else
    bypass     = 1'b0;
    ex_valid_o = ~empty;
    ex_data_o  = mem_q[rp_q];
`endif
    push = id_valid_i & id_ready_o & ~flush_i & ~bypass;
    pop  = ex_valid_o & ex_ready_i & ~flush_i & ~bypass;

    wp_d    = push ? wp_q + PW'(1) : wp_q;
    rp_d    = pop ? rp_q + PW'(1) : rp_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    count_o       = count_q;
    almost_full_o = (count_q >= CW'(AFULL_LEVEL));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wp_q] <= id_data_i;
    end
  end

endmodule

// File: tb/tb_titan_id_queue.sv
// Self-checking bench for titan_id_queue: directed steps then random traffic against a queue model.
module tb_titan_id_queue;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFULL = DEPTH - 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst, flush, id_valid, ex_ready;
  logic [DW-1:0] id_data;
  logic          id_ready, ex_valid, almost_full;
  logic [DW-1:0] ex_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [$];

  titan_id_queue #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .id_valid_i    (id_valid),
    .id_data_i     (id_data),
    .id_ready_o    (id_ready),
    .ex_valid_o    (ex_valid),
    .ex_data_o     (ex_data),
    .ex_ready_i    (ex_ready),
    .count_o       (count),
    .almost_full_o (almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Check outputs mid-cycle against the model, then advance the model by one clock.
  task automatic cycle();
    int unsigned   n;
    logic          e_ready, e_valid, push, pop, byp;
    logic [DW-1:0] e_data;
    @(negedge clk);
    n       = q.size();
    e_ready = !rst && (n != DEPTH);
    e_valid = (n != 0);
    e_data  = (n != 0) ? q[0] : id_data;
    byp     = 1'b0;
`ifdef TITAN_IDQ_BYPASS_EN
    e_valid = (n != 0) || (id_valid && !rst && !flush);
    byp     = (n == 0) && id_valid && ex_ready && !flush && !rst;
`endif
    chk("id_ready", {31'd0, id_ready}, {31'd0, e_ready});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, e_valid});
    chk("count", 32'(count), n);
    chk("almost_full", {31'd0, almost_full}, {31'd0, (n >= AFULL)});
    if (e_valid) chk("ex_data", 32'(ex_data), 32'(e_data));

    if (rst || flush) begin
      q.delete();
    end else if (!byp) begin
      push = id_valid && e_ready;
      pop  = e_valid && ex_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(id_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b1; id_data = 16'h00EE; ex_ready = 1'b0;
    #1;
    // Reset for two cycles with a bundle offered: nothing may be accepted.
    repeat (2) cycle();
    rst = 1'b0; id_valid = 1'b0;
    cycle();

    // Fill past capacity with execute stalled, then drain in order.
    id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      id_data = 16'h00A1 + 16'(i);
      cycle();
    end
    id_valid = 1'b0; ex_ready = 1'b1;
    repeat (5) cycle();

    // Streaming push/pop with incrementing data; pointers wrap several times.
    id_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      id_data = 16'h0100 + 16'(i);
      cycle();
    end
    id_valid = 1'b0;
    repeat (2) cycle();

    // Flush at occupancy 3 while offering 0xB0.
    ex_ready = 1'b0; id_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_data = 16'h00D0 + 16'(i);
      cycle();
    end
    id_data = 16'h00B0; flush = 1'b1;
    cycle();
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    repeat (2) cycle();

    // Reset mid-stream at occupancy 2.
    ex_ready = 1'b0; id_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      id_data = 16'h00E0 + 16'(i);
      cycle();
    end
    rst = 1'b1; id_data = 16'h00E7;
    cycle();
    rst = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    repeat (2) cycle();

    // Empty queue, consumer ready, offer 0xC3 (bypassed or one-cycle latency by build).
    id_valid = 1'b1; id_data = 16'h00C3;
    cycle();
    id_valid = 1'b0;
    repeat (2) cycle();

    // Random traffic; first half favours a slow consumer so the queue fills.
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_data  = 16'($urandom);
      ex_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      rst      = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/titan_id_queue.md
# titan_id_queue

Parametrised elastic decode-to-execute queue, the next generation of the fixed single-entry ID/EX register. It decouples decode from execute with a DEPTH-entry valid/ready FIFO of fully decoded instruction bundles (PC, instruction, operands, control flags packed into one word) instead of a global stall. It supports flush, occupancy reporting and an optional zero-latency bypass. It sits between the decode logic and the execute stage.

## Interface
- DATA_WIDTH, 160: width of the packed decoded bundle.
- DEPTH, 4: entry count. Must be a power of two, minimum 2.
- AFULL_LEVEL, DEPTH-1: occupancy at and above which `almost_full_o` asserts.
- CW (localparam), $clog2(DEPTH+1): counter width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset. Synchronous, active-high.
- flush_i  in  1  discard all entries and the current input (branch/jump/exception redirect).
- id_valid_i  in  1  decode presents a bundle.
- id_data_i  in  DATA_WIDTH  decoded bundle.
- id_ready_o  out  1  queue accepts a bundle this cycle.
- ex_valid_o  out  1  head bundle valid.
- ex_data_o  out  DATA_WIDTH  head bundle.
- ex_ready_i  in  1  execute consumes the head this cycle.
- count_o  out  CW  current occupancy, 0..DEPTH.
- almost_full_o  out  1  count_o >= AFULL_LEVEL.

## Operation
- Storage: DEPTH-entry register array, write pointer `wp`, read pointer `rp`, both log2(DEPTH) bits, plus a CW-bit occupancy counter. Pointers wrap modulo DEPTH naturally; no explicit compare.
- push = id_valid_i & id_ready_o & ~flush_i. pop = ex_valid_o & ex_ready_i & ~flush_i.
- id_ready_o = ~rst_i & (count != DEPTH). It depends only on registered state and rst_i; there is no path from ex_ready_i to id_ready_o. When full, a push in the same cycle as a pop is refused.
- ex_valid_o = (count != 0). ex_data_o = mem[rp], driven from storage. It is undefined (X allowed) when ex_valid_o = 0.
- Counter update: push & ~pop → +1. pop & ~push → −1. Both or neither → unchanged.
- Simultaneous push and pop with count = 1: the head is consumed, the new bundle becomes head next cycle, and count stays 1.
- flush_i = 1: wp, rp and count clear to 0 next cycle. The bundle on id_data_i is dropped. A pop in that cycle is not counted; execute must qualify ex_ready_i with its own flush handling. Flush has priority over push and pop.
- rst_i = 1: same clearing as flush. It also forces id_ready_o = 0, so no push is accepted during reset. Storage contents are not cleared.
- Reset mid-operation: all in-flight entries are lost; the first cycle after deassertion shows the queue empty and ready.
- almost_full_o is combinational from count.

## Timing
- Reset values: ex_valid_o = 0, count_o = 0, almost_full_o = 0 (AFULL_LEVEL ≥ 1), id_ready_o = 0 while rst_i is high and 1 the cycle after.
- Latency (no bypass): a bundle accepted in cycle N is at ex_data_o with ex_valid_o = 1 in cycle N+1.
- Throughput: one push and one pop per cycle sustained at any occupancy in 1..DEPTH−1.
- Full: id_ready_o drops the cycle after count reaches DEPTH and rises the cycle after the first pop.
- Data is held stable at the head while ex_valid_o = 1 and ex_ready_i = 0.

## Configuration
- TITAN_IDQ_BYPASS_EN defined:
  - When count = 0, id_valid_i = 1 and ex_ready_i = 1 and flush_i = 0, id_data_i is passed combinationally to ex_data_o and ex_valid_o = 1 in the same cycle.
  - The bundle is not written and count stays 0.
  - ex_valid_o = (count != 0) | (id_valid_i & ~rst_i & ~flush_i). When count = 0, ex_data_o = id_data_i.
  - If ex_ready_i = 0, the bundle is stored normally.
- Not defined: no combinational input-to-output path. Latency is always 1 cycle.

## Test plan
- Reset for 2 cycles with id_valid_i = 1: no push occurs; after release count_o = 0, ex_valid_o = 0, id_ready_o = 1.
- DEPTH = 4, ex_ready_i = 0, push 0xA1..0xA5 on consecutive cycles: 0xA1..0xA4 are accepted; id_ready_o = 0 from cycle 4; count_o = 4 and almost_full_o = 1 at count 3. Then ex_ready_i = 1: outputs are 0xA1, 0xA2, 0xA3, 0xA4 in order.
- Continuous push/pop for 20 cycles with incrementing data: count_o stays 1, ex_data_o lags the input by exactly one cycle, and the pointers wrap past DEPTH with no loss.
- Count = 3 and flush_i = 1 while pushing 0xB0: next cycle count_o = 0, ex_valid_o = 0, and 0xB0 never appears.
- rst_i asserted at count = 2 mid-stream: the next cycle is empty; pre-reset bundles are never output.
- TITAN_IDQ_BYPASS_EN defined, empty queue, ex_ready_i = 1, push 0xC3: ex_data_o = 0xC3 and ex_valid_o = 1 in the same cycle, and count_o stays 0. Without the macro, 0xC3 appears one cycle later.
